// File: rtl/soc_dbus_pkg.sv
// Shared types and constants for the data-bus fabric: FSM states, error
// response data and error-counter width.
package soc_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dbus_state_e;

  // Errored completions return all-zero data, replicated to DATA_W by users.
  localparam logic ERR_DATA_BIT = 1'b0;
  localparam int   ERR_CNT_W    = 8;

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational address decode: slave-select field to one-hot target select,
// with a miss flag when the field names a target that does not exist.
module dbus_addr_decode #(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel_oh,
  output logic               miss
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [SEL_W-1:0] sel;
  logic             unused_addr;

  assign sel         = addr[SEL_LSB +: SEL_W];
  assign unused_addr = ^addr;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_oh[i] = (int'(sel) == i);
    end
  end

  // Select values at or above NUM_SLV leave the one-hot vector empty.
  assign miss = ~|sel_oh;

endmodule

// File: rtl/soc_dbus_fabric.sv
// Data-bus fabric: one master port to NUM_SLV request/ack targets.
// Define DBUS_TIMEOUT_EN to fail transactions whose target never acks.
module soc_dbus_fabric
  import soc_dbus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_req,
  input  logic                      m_we,
  input  logic [DATA_W/8-1:0]       m_mask,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic                      m_ready,
  output logic                      m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_err,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic [NUM_SLV-1:0]        s_req,
  output logic                      s_we,
  output logic [DATA_W/8-1:0]       s_mask,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NUM_SLV-1:0]        s_ack,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata
);

  localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_DATA_BIT}};

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  dbus_state_e          state;
  logic [NUM_SLV-1:0]   sel_oh;
  logic [NUM_SLV-1:0]   dec_oh;
  logic                 dec_miss;
  logic                 ack_hit;
  logic [DATA_W-1:0]    ack_rdata;

`ifdef DBUS_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  dbus_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .addr   (m_addr),
    .sel_oh (dec_oh),
    .miss   (dec_miss)
  );

  assign m_ready = (state == IDLE);
  assign ack_hit = |(s_ack & sel_oh);

  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_oh[i]) ack_rdata = s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sel_oh   <= '0;
      s_req    <= '0;
      s_we     <= 1'b0;
      s_mask   <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      m_rvalid <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      err_cnt  <= '0;
`ifdef DBUS_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      m_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (m_req) begin
            s_we    <= m_we;
            s_mask  <= m_mask;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            sel_oh  <= dec_oh;
`ifdef DBUS_TIMEOUT_EN
            tcnt    <= '0;
`endif
            if (dec_miss) begin
              state    <= RESP;
              m_rvalid <= 1'b1;
              m_err    <= 1'b1;
              m_rdata  <= ERR_RDATA;
              err_cnt  <= sat_inc(err_cnt);
            end else begin
              state <= WAIT;
              s_req <= dec_oh;
            end
          end
        end
        WAIT: begin
          // An ack in the timeout cycle takes priority over the timeout.
          if (ack_hit) begin
            state    <= RESP;
            s_req    <= '0;
            m_rvalid <= 1'b1;
            m_err    <= 1'b0;
            m_rdata  <= s_we ? ERR_RDATA : ack_rdata;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            state    <= RESP;
            s_req    <= '0;
            m_rvalid <= 1'b1;
            m_err    <= 1'b1;
            m_rdata  <= ERR_RDATA;
            err_cnt  <= sat_inc(err_cnt);
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_dbus_fabric.sv
// Directed bench for soc_dbus_fabric with five targets so that select
// values 5..7 exercise the decode-miss path.
module tb_soc_dbus_fabric;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      m_req;
  logic                      m_we;
  logic [DATA_W/8-1:0]       m_mask;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_ready;
  logic                      m_rvalid;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_err;
  logic [7:0]                err_cnt;
  logic [NUM_SLV-1:0]        s_req;
  logic                      s_we;
  logic [DATA_W/8-1:0]       s_mask;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic [NUM_SLV-1:0]        s_ack;
  logic [NUM_SLV*DATA_W-1:0] s_rdata;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_ecnt = 0;
  int pulses;

  soc_dbus_fabric #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (28),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_mask   (m_mask),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .err_cnt  (err_cnt),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_mask   (s_mask),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rdata  (s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to completion. ack_at is the WAIT cycle
  // (1-based) in which the selected target acks; 0 means it never acks.
  // spur is driven on s_ack in every other cycle to model foreign acks.
  task automatic txn(input string tag, input logic we, input logic [3:0] mask,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [4:0] exp_sreq, input int ack_at,
                     input logic [4:0] spur, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rdata);
    int lat;
    bit done;
    m_req = 1'b1; m_we = we; m_mask = mask; m_addr = addr; m_wdata = wdata;
    s_ack = '0;
    tick();
    m_req = 1'b0; m_we = 1'b0; m_mask = '0; m_addr = '0; m_wdata = '0;
    lat = 1;
    done = 1'b0;
    while (!done && lat <= 40) begin
      if (m_rvalid) begin
        done = 1'b1;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".err"}, m_err, exp_err);
        chk({tag, ".rdata"}, m_rdata, exp_rdata);
        chk({tag, ".sreq_resp"}, s_req, 5'b0);
        s_ack = '0;
      end else begin
        chk({tag, ".sreq"}, s_req, exp_sreq);
        chk({tag, ".ready_wait"}, m_ready, 1'b0);
        chk({tag, ".bcast_ctl"}, {s_we, s_mask, s_addr}, {we, mask, addr});
        chk({tag, ".bcast_wdata"}, s_wdata, wdata);
        s_ack = (lat == ack_at) ? (exp_sreq | spur) : spur;
        lat++;
        tick();
      end
    end
    if (!done) chk({tag, ".rvalid_seen"}, 1'b0, 1'b1);
    s_ack = '0;
    tick();
    chk({tag, ".single_pulse"}, m_rvalid, 1'b0);
    chk({tag, ".ready_after"}, m_ready, 1'b1);
    if (exp_err && exp_ecnt < 255) exp_ecnt++;
    chk({tag, ".err_cnt"}, err_cnt, exp_ecnt);
  endtask

  initial begin
    rst = 1'b0; m_req = 1'b0; m_we = 1'b0; m_mask = '0; m_addr = '0; m_wdata = '0;
    s_ack = 5'b11111;
    s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    repeat (3) tick();
    chk("rst.ready", m_ready, 1'b1);
    chk("rst.rvalid", m_rvalid, 1'b0);
    chk("rst.err", m_err, 1'b0);
    chk("rst.rdata", m_rdata, 32'h0);
    chk("rst.err_cnt", err_cnt, 8'd0);
    chk("rst.sreq", s_req, 5'b0);
    chk("rst.bcast", {s_we, s_mask, s_addr, s_wdata}, 64'h0);
    s_ack = '0;
    rst = 1'b1;
    tick();

    txn("rd_s1", 1'b0, 4'hF, 32'h1000_0040, 32'h0, 5'b00010, 3, 5'b0, 4, 1'b0, 32'hDEAD_BEEF);
    txn("wr_s0", 1'b1, 4'b0011, 32'h0000_0100, 32'hA5A5_1234, 5'b00001, 1, 5'b0, 2, 1'b0, 32'h0);
    txn("rd_s4", 1'b0, 4'hF, 32'h4000_0008, 32'h0, 5'b10000, 2, 5'b0, 3, 1'b0, 32'h4444_4444);
    txn("miss5", 1'b0, 4'hF, 32'h5000_0000, 32'h0, 5'b0, 0, 5'b0, 1, 1'b1, 32'h0);
    txn("miss7w", 1'b1, 4'hF, 32'h7000_0010, 32'hFFFF_FFFF, 5'b0, 0, 5'b0, 1, 1'b1, 32'h0);
    txn("spur", 1'b0, 4'hF, 32'h0000_0040, 32'h0, 5'b00001, 3, 5'b00100, 4, 1'b0, 32'h1111_1111);

`ifdef DBUS_TIMEOUT_EN
    txn("to_never", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 5'b01000, 0, 5'b0, 16, 1'b1, 32'h0);
    txn("to_ack15", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 5'b01000, 15, 5'b0, 16, 1'b0, 32'h3333_3333);
`else
    txn("long_wait", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 5'b01000, 20, 5'b0, 21, 1'b0, 32'h3333_3333);
`endif

    // Acks while idle must not produce a completion.
    s_ack = 5'b11111;
    tick();
    tick();
    chk("idle_ack.rvalid", m_rvalid, 1'b0);
    chk("idle_ack.ready", m_ready, 1'b1);
    chk("idle_ack.sreq", s_req, 5'b0);
    chk("idle_ack.err_cnt", err_cnt, exp_ecnt);
    s_ack = '0;

    // Held miss request: back-to-back every two cycles, counter saturates.
    m_req = 1'b1; m_addr = 32'h5000_0000; m_we = 1'b0;
    pulses = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (m_rvalid) pulses++;
    end
    m_req = 1'b0; m_addr = '0;
    chk("b2b.pulses", pulses, 300);
    tick();
    exp_ecnt = 255;
    chk("sat.err_cnt", err_cnt, exp_ecnt);

    // Reset in the middle of a WAIT discards the transaction.
    m_req = 1'b1; m_addr = 32'h2000_0000;
    tick();
    m_req = 1'b0; m_addr = '0;
    chk("rstw.sreq_wait", s_req, 5'b00100);
    rst = 1'b0;
    tick();
    chk("rstw.sreq", s_req, 5'b0);
    chk("rstw.rvalid", m_rvalid, 1'b0);
    chk("rstw.err_cnt", err_cnt, 8'd0);
    chk("rstw.ready", m_ready, 1'b1);
    rst = 1'b1;
    exp_ecnt = 0;
    s_ack = 5'b00100;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_rvalid) pulses++;
    end
    s_ack = '0;
    chk("rstw.stale", pulses, 0);
    txn("post_rst", 1'b0, 4'hF, 32'h3000_0000, 32'h0, 5'b01000, 1, 5'b0, 2, 1'b0, 32'h3333_3333);
    txn("post_miss", 1'b0, 4'hF, 32'h6000_0000, 32'h0, 5'b0, 0, 5'b0, 1, 1'b1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
